// File: rtl/dcache_pkg.sv
// Shared types and constants for the parameterised set-associative data cache.
package dcache_pkg;

    localparam logic [31:0] HIT_CNT_ADDR = 32'h0000_3100;

    typedef enum logic [2:0] {
        TAG, WB, ALLOC, FLUSH_SCAN, FLUSH_WB, CNT_WR, DONE
    } state_t;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// True-LRU age tracking per set (0 = MRU) with victim selection.
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 8,
    parameter int WW   = 1,
    parameter int IW   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IW-1:0]   idx,
    input  logic [WAYS-1:0] set_valid,
    input  logic            touch,
    input  logic [WW-1:0]   touch_way,
    output logic [WW-1:0]   victim
);

    logic [WW-1:0] age_q [SETS][WAYS];
    logic [WW-1:0] old_age;
    logic          found;

    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!set_valid[w] && !found) begin
                victim = WW'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++)
                if (age_q[idx][w] == WW'(WAYS - 1)) victim = WW'(w);
        end
    end

    // A fill into an empty way acts as if it came from the oldest slot, so the
    // ages settle into a permutation once the set is full.
    assign old_age = set_valid[touch_way] ? age_q[idx][touch_way] : WW'(WAYS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= '0;
        end else if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WW'(w) == touch_way)
                    age_q[idx][w] <= '0;
                else if (age_q[idx][w] < old_age)
                    age_q[idx][w] <= age_q[idx][w] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_assoc_param.sv
// N-way write-back/write-allocate data cache with LRU and halt flush.
// Define DCACHE_HIT_COUNT_EN to add the net hit counter written out after the flush.
module dcache_assoc_param
    import dcache_pkg::*;
#(
    parameter int WAYS      = 2,
    parameter int SETS      = 8,
    parameter int BLK_WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);

    localparam int BO   = $clog2(BLK_WORDS);
    localparam int IW   = $clog2(SETS);
    localparam int TW   = 30 - BO - IW;
    localparam int CW   = width_of(BLK_WORDS);
    localparam int WW   = width_of(WAYS);
    localparam int WB_B = $clog2(WAYS);
    localparam int FW   = $clog2(SETS * WAYS) + 1;

    typedef struct packed {
        logic                         valid;
        logic                         dirty;
        logic [TW-1:0]                tag;
        logic [BLK_WORDS-1:0][31:0]   data;
    } frame_t;

    frame_t        frame_q [WAYS][SETS];
    state_t        state, next;
    logic [CW-1:0] cnt;
    logic [FW-1:0] fcnt;
    logic [WW-1:0] vic_q, hit_way, lru_victim, touch_way;
    logic [WAYS-1:0] set_valid;
    logic [IW-1:0] idx, fset;
    logic [TW-1:0] tag;
    logic [CW-1:0] boff;
    logic [WW-1:0] fway;
    logic          req, hit_any, hit, miss, last, fill_done, fdone, touch;
    logic [1:0]    unused_bytoff;

    assign unused_bytoff = dmemaddr[1:0];
    assign idx  = dmemaddr[BO+2 +: IW];
    assign tag  = dmemaddr[31 -: TW];
    assign boff = (BLK_WORDS == 1) ? '0 : dmemaddr[2 +: CW];
    assign fway = (WAYS == 1) ? '0 : fcnt[WW-1:0];
    assign fset = fcnt[WB_B +: IW];
    assign fdone = fcnt[FW-1];
    assign last = (cnt == CW'(BLK_WORDS - 1));

    function automatic logic [31:0] word_addr(input logic [TW-1:0] t, input logic [IW-1:0] s,
                                              input logic [CW-1:0] c);
        return (32'({t, s}) << (BO + 2)) | (32'(c) << 2);
    endfunction

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            set_valid[w] = frame_q[w][idx].valid;
            if (frame_q[w][idx].valid && frame_q[w][idx].tag == tag) begin
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    assign req       = dmemREN | dmemWEN;
    assign hit       = (state == TAG) && req && hit_any;
    assign miss      = (state == TAG) && req && !hit_any;
    assign fill_done = (state == ALLOC) && !dwait && last;
    assign touch     = hit || fill_done;
    assign touch_way = (state == ALLOC) ? vic_q : hit_way;

    dcache_lru #(.WAYS(WAYS), .SETS(SETS), .WW(WW), .IW(IW)) u_lru (
        .clk(CLK), .rst(RST), .idx(idx), .set_valid(set_valid),
        .touch(touch), .touch_way(touch_way), .victim(lru_victim)
    );

`ifdef DCACHE_HIT_COUNT_EN
    logic [31:0] hit_cnt;
    always_ff @(posedge CLK) begin
        if (RST)                              hit_cnt <= '0;
        else if (hit && hit_cnt != '1)        hit_cnt <= hit_cnt + 1'b1;
        else if (miss && hit_cnt != '0)       hit_cnt <= hit_cnt - 1'b1;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= TAG;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            TAG: begin
                if (miss)               next = frame_q[lru_victim][idx].dirty ? WB : ALLOC;
                else if (!req && halt)  next = FLUSH_SCAN;
            end
            WB:       if (!dwait && last) next = ALLOC;
            ALLOC:    if (fill_done)      next = TAG;
            FLUSH_SCAN: begin
                if (fdone) begin
`ifdef DCACHE_HIT_COUNT_EN
                    next = CNT_WR;
`else
                    next = DONE;
`endif
                end else if (frame_q[fway][fset].dirty) begin
                    next = FLUSH_WB;
                end
            end
            FLUSH_WB: if (!dwait && last) next = FLUSH_SCAN;
            CNT_WR:   if (!dwait)         next = DONE;
            DONE:     next = DONE;
            default:  next = TAG;
        endcase
    end

    always_comb begin
        dhit     = hit;
        dmemload = hit ? frame_q[hit_way][idx].data[boff] : '0;
        flushed  = (state == DONE);
        dREN     = (state == ALLOC);
        dWEN     = (state == WB) || (state == FLUSH_WB) || (state == CNT_WR);
        daddr    = '0;
        dstore   = '0;
        case (state)
            WB: begin
                daddr  = word_addr(frame_q[vic_q][idx].tag, idx, cnt);
                dstore = frame_q[vic_q][idx].data[cnt];
            end
            ALLOC:    daddr = word_addr(tag, idx, cnt);
            FLUSH_WB: begin
                daddr  = word_addr(frame_q[fway][fset].tag, fset, cnt);
                dstore = frame_q[fway][fset].data[cnt];
            end
            CNT_WR: begin
                daddr  = HIT_CNT_ADDR;
`ifdef DCACHE_HIT_COUNT_EN
                dstore = hit_cnt;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++) begin
                    frame_q[w][s].valid <= 1'b0;
                    frame_q[w][s].dirty <= 1'b0;
                end
            cnt   <= '0;
            fcnt  <= '0;
            vic_q <= '0;
        end else begin
            case (state)
                TAG: begin
                    if (hit && dmemWEN) begin
                        frame_q[hit_way][idx].data[boff] <= dmemstore;
                        frame_q[hit_way][idx].dirty      <= 1'b1;
                    end
                    // Latch the victim so the miss sequence is immune to LRU updates.
                    if (miss) begin
                        vic_q <= lru_victim;
                        cnt   <= '0;
                    end
                end
                WB: if (!dwait) begin
                    if (last) begin
                        cnt <= '0;
                        frame_q[vic_q][idx].dirty <= 1'b0;
                    end else cnt <= cnt + 1'b1;
                end
                ALLOC: if (!dwait) begin
                    frame_q[vic_q][idx].data[cnt] <= dload;
                    if (last) begin
                        cnt <= '0;
                        frame_q[vic_q][idx].valid <= 1'b1;
                        frame_q[vic_q][idx].dirty <= 1'b0;
                        frame_q[vic_q][idx].tag   <= tag;
                    end else cnt <= cnt + 1'b1;
                end
                FLUSH_SCAN: if (!fdone && !frame_q[fway][fset].dirty) fcnt <= fcnt + 1'b1;
                FLUSH_WB: if (!dwait) begin
                    if (last) begin
                        cnt  <= '0;
                        fcnt <= fcnt + 1'b1;
                        frame_q[fway][fset].dirty <= 1'b0;
                    end else cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
